bus_activity_monitor: RTL and testbench

//  Downstream observer of the registered Gray-coded bus (B) produced by the encoder stage.

---
 rtl/bus_mon_pkg.sv | 22 ++
 rtl/bus_activity_monitor_popcount.sv | 22 ++
 rtl/bus_activity_monitor.sv | 140 ++++++++++++++
 tb/tb_bus_activity_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_mon_pkg.sv
// Shared types and helpers for the bus activity monitor: FSM state encoding
// and the Hamming-distance result width.
package bus_mon_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      PRIME = ST_PRIME,
      COUNT = ST_COUNT,
      HOLD  = ST_HOLD
   } state_e;

   // Bits needed to hold a distance of 0..w.
   function automatic int hd_w(input int w);
      return $clog2(w + 32'sd1);
   endfunction

endpackage

// File: rtl/bus_activity_monitor_popcount.sv
// Combinational Hamming distance between two bus words.
module popcount
   import bus_mon_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0]        a,
   input  logic [W-1:0]        b,
   output logic [hd_w(W)-1:0]  cnt
);

   localparam int HW = hd_w(W);

   // Sum the differing bit positions.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) begin
         cnt = cnt + HW'(a[i] ^ b[i]);
      end
   end

endmodule

// File: rtl/bus_activity_monitor.sv
// Measures bit toggles and peak per-step Hamming distance of a bus over a
// programmable window of samples; reports through a valid/ready port.
module bus_activity_monitor
   import bus_mon_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int LEN_W = 16
) (
   input  logic                ck,
   input  logic                rst,
   input  logic [W-1:0]        bus_in,
   input  logic                sample_en,
   input  logic                start,
   input  logic [LEN_W-1:0]    window_len,
   output logic                busy,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CNT_W-1:0]    res_count,
   output logic [hd_w(W)-1:0]  res_max_hd,
   output logic                res_sat
);

   localparam int HW = hd_w(W);
   localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ACC_MAX = '1;

   state_e            state_r, state_s;
   logic [W-1:0]      prev_r;
   logic [LEN_W-1:0]  remaining_r;
   logic [CNT_W-1:0]  acc_r, acc_s;
   logic [HW-1:0]     max_r, max_s, hd_s;
   logic              sat_r, sat_s;
   logic [CNT_W:0]    sum_s;

   popcount #(.W(W)) u_popcount (
      .a   (bus_in),
      .b   (prev_r),
      .cnt (hd_s)
   );

   // FSM state register.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start) state_s = PRIME; else state_s = IDLE;
         PRIME: begin
            if (sample_en) begin
               if (window_len == '0) state_s = HOLD; else state_s = COUNT;
            end else begin
               state_s = PRIME;
            end
         end
         COUNT:   if (sample_en && (remaining_r == ONE_LEN)) state_s = HOLD; else state_s = COUNT;
         HOLD:    if (res_ready) state_s = IDLE; else state_s = HOLD;
         default: state_s = IDLE;
      endcase
   end

   // Saturating accumulate and running maximum for the current sample.
   always_comb begin
      sum_s = {1'b0, acc_r} + (CNT_W + 1)'(hd_s);
      if (sum_s[CNT_W]) begin
         acc_s = ACC_MAX;
         sat_s = 1'b1;
      end else begin
         acc_s = sum_s[CNT_W-1:0];
         sat_s = sat_r;
      end
      if (hd_s > max_r) max_s = hd_s; else max_s = max_r;
   end

   // Datapath and registered result/status outputs.
   always_ff @(posedge ck) begin
      if (rst) begin
         prev_r      <= '0;
         remaining_r <= '0;
         acc_r       <= '0;
         max_r       <= '0;
         sat_r       <= 1'b0;
         res_count   <= '0;
         res_max_hd  <= '0;
         res_sat     <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
      end else begin
         busy      <= (state_s != IDLE);
         res_valid <= (state_s == HOLD);
         case (state_r)
            IDLE: begin
               if (start) begin
                  acc_r <= '0;
                  max_r <= '0;
                  sat_r <= 1'b0;
               end
            end
            PRIME: begin
               if (sample_en) begin
                  prev_r      <= bus_in;
                  remaining_r <= window_len;
                  if (window_len == '0) begin
                     res_count  <= '0;
                     res_max_hd <= '0;
                     res_sat    <= 1'b0;
                  end
               end
            end
            COUNT: begin
               if (sample_en) begin
                  acc_r       <= acc_s;
                  max_r       <= max_s;
                  sat_r       <= sat_s;
                  prev_r      <= bus_in;
                  remaining_r <= remaining_r - ONE_LEN;
                  // Final transition: publish including this sample's distance.
                  if (remaining_r == ONE_LEN) begin
                     res_count  <= acc_s;
                     res_max_hd <= max_s;
                     res_sat    <= sat_s;
                  end
               end
            end
            HOLD: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Scoreboard bench: two monitors (CNT_W=16 and CNT_W=4) see identical stimulus;
// expected results come from a plain arithmetic model of the window.
module tb_bus_activity_monitor;

   logic        ck = 1'b0;
   logic        rst;
   logic [7:0]  bus_in;
   logic        sample_en;
   logic        start;
   logic [15:0] window_len;
   logic        res_ready;

   logic        busy16, res_valid16, res_sat16;
   logic [15:0] res_count16;
   logic [3:0]  res_max_hd16;
   logic        busy4, res_valid4, res_sat4;
   logic [3:0]  res_count4;
   logic [3:0]  res_max_hd4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int cnt;
      int mx;
      int sat;
   } exp_t;

   exp_t q16[$];
   exp_t q4[$];
   logic [7:0] words [0:15];

   always #5 ck = ~ck;

   bus_activity_monitor #(.W(8), .CNT_W(16), .LEN_W(16)) dut16 (
      .ck(ck), .rst(rst), .bus_in(bus_in), .sample_en(sample_en), .start(start),
      .window_len(window_len), .busy(busy16), .res_valid(res_valid16), .res_ready(res_ready),
      .res_count(res_count16), .res_max_hd(res_max_hd16), .res_sat(res_sat16)
   );

   bus_activity_monitor #(.W(8), .CNT_W(4), .LEN_W(16)) dut4 (
      .ck(ck), .rst(rst), .bus_in(bus_in), .sample_en(sample_en), .start(start),
      .window_len(window_len), .busy(busy4), .res_valid(res_valid4), .res_ready(res_ready),
      .res_count(res_count4), .res_max_hd(res_max_hd4), .res_sat(res_sat4)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // Reference: toggles of the first L transitions, clipped at 2^cw-1.
   function automatic exp_t model(input int L, input int cw);
      exp_t e;
      int sum, hd, lim;
      sum = 0;
      e.mx = 0;
      for (int i = 1; i <= L; i++) begin
         hd = $countones(words[i] ^ words[i-1]);
         sum += hd;
         if (hd > e.mx) e.mx = hd;
      end
      lim = (1 << cw) - 1;
      e.sat = (sum > lim) ? 1 : 0;
      e.cnt = (sum > lim) ? lim : sum;
      return e;
   endfunction

   // Monitor for the 16-bit accumulator instance.
   always @(negedge ck) begin
      if (!rst && res_valid16) begin
         if (q16.size() == 0) begin
            chk("unexpected_result16", 1, 0);
         end else begin
            chk("count16", int'(res_count16), q16[0].cnt);
            chk("maxhd16", int'(res_max_hd16), q16[0].mx);
            chk("sat16", int'(res_sat16), q16[0].sat);
            if (res_ready) void'(q16.pop_front());
         end
      end
   end

   // Monitor for the 4-bit accumulator instance.
   always @(negedge ck) begin
      if (!rst && res_valid4) begin
         if (q4.size() == 0) begin
            chk("unexpected_result4", 1, 0);
         end else begin
            chk("count4", int'(res_count4), q4[0].cnt);
            chk("maxhd4", int'(res_max_hd4), q4[0].mx);
            chk("sat4", int'(res_sat4), q4[0].sat);
            if (res_ready) void'(q4.pop_front());
         end
      end
   end

   // One full measurement over words[0..L], with optional gaps and backpressure.
   task automatic run(input int L, input bit gaps, input int delay, input bit stray);
      start = 1'b1;
      tick();
      start = 1'b0;
      q16.push_back(model(L, 16));
      q4.push_back(model(L, 4));
      for (int k = 0; k <= L; k++) begin
         while (gaps && ($urandom_range(0, 3) == 0)) begin
            sample_en  = 1'b0;
            bus_in     = 8'($urandom);
            window_len = 16'($urandom);
            tick();
         end
         sample_en  = 1'b1;
         bus_in     = words[k];
         window_len = (k == 0) ? 16'(L) : 16'($urandom);
         tick();
      end
      sample_en = 1'b0;
      @(negedge ck);
      chk("latency_valid16", int'(res_valid16), 1);
      chk("latency_valid4", int'(res_valid4), 1);
      for (int d = 0; d < delay; d++) begin
         sample_en = 1'($urandom);
         bus_in    = 8'($urandom);
         start     = stray ? 1'($urandom) : 1'b0;
         tick();
      end
      sample_en = 1'b0;
      res_ready = 1'b1;
      start     = stray ? 1'b1 : 1'b0;
      tick();
      res_ready = 1'b0;
      start     = 1'b0;
      @(negedge ck);
      chk("idle_busy16", int'(busy16), 0);
      chk("idle_valid16", int'(res_valid16), 0);
      chk("idle_busy4", int'(busy4), 0);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bus_in = 8'h00; sample_en = 1'b0; start = 1'b0;
      window_len = 16'h0000; res_ready = 1'b0;
      repeat (3) tick();
      @(negedge ck);
      chk("rst_busy", int'(busy16), 0);
      chk("rst_valid", int'(res_valid16), 0);
      chk("rst_count", int'(res_count16), 0);
      chk("rst_maxhd", int'(res_max_hd16), 0);
      chk("rst_sat", int'(res_sat16), 0);
      rst = 1'b0;
      tick();

      words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h00;
      run(2, 1'b0, 0, 1'b0);

      words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h03; words[3] = 8'h02;
      words[4] = 8'h06; words[5] = 8'h07; words[6] = 8'h05; words[7] = 8'h04;
      run(7, 1'b0, 0, 1'b0);

      words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h00; words[3] = 8'hFF;
      run(3, 1'b0, 0, 1'b0);

      words[0] = 8'hA5;
      run(0, 1'b0, 0, 1'b0);

      words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h0F;
      run(2, 1'b0, 5, 1'b1);
      chk("no_new_meas_busy16", int'(busy16), 0);

      // Abort mid-window: prime plus two counted samples, then reset.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample_en  = 1'b1;
         bus_in     = 8'($urandom);
         window_len = (k == 0) ? 16'd5 : 16'($urandom);
         tick();
      end
      sample_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge ck);
      chk("abort_busy16", int'(busy16), 0);
      chk("abort_valid16", int'(res_valid16), 0);
      chk("abort_count16", int'(res_count16), 0);
      chk("abort_count4", int'(res_count4), 0);
      tick();

      for (int r = 0; r < 25; r++) begin
         int len;
         len = $urandom_range(0, 12);
         for (int k = 0; k <= len; k++) words[k] = 8'($urandom);
         run(len, 1'b1, $urandom_range(0, 3), 1'($urandom));
      end

      chk("queue16_empty", q16.size(), 0);
      chk("queue4_empty", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
